// File: rtl/move_collector.sv
// Round-robin collector that drains eight column FIFOs into one move stream.
// Optional feature: define MOVE_COUNT_EN to build the accepted-move counter (mv_count).
module move_collector (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [7:0]   i_col_done,
    input  logic [7:0]   i_col_empty,
    output logic [7:0]   o_col_rden,
    input  logic [383:0] i_col_data,
    output logic [47:0]  o_mv_data,
    output logic         o_mv_valid,
    input  logic         i_mv_ready,
    output logic         o_busy,
    output logic         o_all_done,
    output logic [9:0]   o_mv_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_READ = 3'd2,
        S_CAPT = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_finished;
    logic [2:0]  r_rr_ptr;
    logic [2:0]  r_sel;
    logic [7:0]  r_col_rden;
    logic [47:0] r_mv_data;
    logic        r_mv_valid;
    logic        r_busy;
    logic        r_all_done;

    logic [7:0]  w_elig;
    logic        w_found;
    logic [2:0]  w_pick;
    logic [2:0]  w_idx;
    logic [47:0] w_word;
    logic        w_start_ok;
    logic        w_accept;

    // A list ends with a word whose eight 6-bit fields are all identical.
    function automatic logic is_marker(input logic [47:0] word);
        logic same;
        same = 1'b1;
        for (int f = 1; f < 8; f++) begin
            same = same & (word[f*6 +: 6] == word[5:0]);
        end
        return same;
    endfunction

    assign w_elig     = i_col_done & ~r_finished & ~i_col_empty;
    assign w_found    = |w_elig;
    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept   = (r_state == S_OUT) && r_mv_valid && i_mv_ready;

    // First eligible column at or above rr_ptr; descending walk lets the nearest win.
    always_comb begin
        w_pick = 3'd0;
        w_idx  = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_idx  = r_rr_ptr + 3'(k);
            w_pick = w_elig[w_idx] ? w_idx : w_pick;
        end
    end

    // Mux out the selected column's word from the flat data bus.
    always_comb begin
        w_word = 48'd0;
        for (int k = 0; k < 8; k++) begin
            w_word = (r_sel == 3'(k)) ? i_col_data[k*48 +: 48] : w_word;
        end
    end

    // Main controller: state, selection, FIFO strobe and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_finished <= 8'd0;
            r_rr_ptr   <= 3'd0;
            r_sel      <= 3'd0;
            r_col_rden <= 8'd0;
            r_mv_data  <= 48'd0;
            r_mv_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_all_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state    <= S_SCAN;
                        r_finished <= 8'd0;
                        r_rr_ptr   <= 3'd0;
                        r_busy     <= 1'b1;
                        r_all_done <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (r_finished == 8'hFF) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_all_done <= 1'b1;
                    end else if (w_found) begin
                        r_sel      <= w_pick;
                        r_col_rden <= 8'd1 << w_pick;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_col_rden <= 8'd0;
                    r_state    <= S_CAPT;
                end
                S_CAPT: begin
                    if (is_marker(w_word)) begin
                        r_finished[r_sel] <= 1'b1;
                        r_rr_ptr          <= r_sel + 3'd1;
                        r_state           <= S_SCAN;
                    end else begin
                        r_mv_data  <= w_word;
                        r_mv_valid <= 1'b1;
                        r_state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_mv_ready) begin
                        r_mv_valid <= 1'b0;
                        // Keep draining the same column until its marker shows up.
                        if (!i_col_empty[r_sel]) begin
                            r_col_rden <= 8'd1 << r_sel;
                            r_state    <= S_READ;
                        end else begin
                            r_state    <= S_SCAN;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_col_rden <= 8'd0;
                    r_mv_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_all_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef MOVE_COUNT_EN
    logic [9:0] r_mv_count;

    // Saturating count of words accepted downstream during this pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mv_count <= 10'd0;
        end else if (w_start_ok) begin
            r_mv_count <= 10'd0;
        end else if (w_accept && (r_mv_count != 10'd1023)) begin
            r_mv_count <= r_mv_count + 10'd1;
        end
    end

    assign o_mv_count = r_mv_count;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = w_start_ok ^ w_accept;
    assign o_mv_count   = 10'd0;
`endif

    assign o_col_rden = r_col_rden;
    assign o_mv_data  = r_mv_data;
    assign o_mv_valid = r_mv_valid;
    assign o_busy     = r_busy;
    assign o_all_done = r_all_done;

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: column FIFO model, handshake monitor, six scenarios.
module tb_move_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_start;
    logic [7:0]   i_col_done;
    logic [7:0]   i_col_empty;
    logic [7:0]   o_col_rden;
    logic [383:0] i_col_data;
    logic [47:0]  o_mv_data;
    logic         o_mv_valid;
    logic         i_mv_ready;
    logic         o_busy;
    logic         o_all_done;
    logic [9:0]   o_mv_count;

    always #5 clk = ~clk;

    move_collector dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_col_done  (i_col_done),
        .i_col_empty (i_col_empty),
        .o_col_rden  (o_col_rden),
        .i_col_data  (i_col_data),
        .o_mv_data   (o_mv_data),
        .o_mv_valid  (o_mv_valid),
        .i_mv_ready  (i_mv_ready),
        .o_busy      (o_busy),
        .o_all_done  (o_all_done),
        .o_mv_count  (o_mv_count)
    );

`ifdef MOVE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [47:0] MARK = 48'hFFFF_FFFF_FFFF;
    localparam int DEPTH = 1100;

    logic [47:0] mem [8][DEPTH];
    int          wr_cnt [8];
    int          rd_ptr [8];
    logic        fifo_clr;
    logic [47:0] beats [$];
    int          rden_cnt [8];
    int          multi_hot = 0;
    int          checks = 0;
    int          errors = 0;

    for (genvar g = 0; g < 8; g++) begin : g_empty
        assign i_col_empty[g] = (rd_ptr[g] >= wr_cnt[g]);
    end

    // Column FIFO model: a read strobe returns the head word on the next cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (fifo_clr) begin
                rd_ptr[i] <= 0;
            end else if (o_col_rden[i] && rd_ptr[i] < DEPTH) begin
                i_col_data[i*48 +: 48] <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    // Log every accepted word and every read strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_mv_valid && i_mv_ready && !reset) beats.push_back(o_mv_data);
        for (int i = 0; i < 8; i++) begin
            if (o_col_rden[i]) rden_cnt[i] <= rden_cnt[i] + 1;
        end
        if ($countones(o_col_rden) > 1) multi_hot <= multi_hot + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] wd(input int v);
        return {16'hA5C3, 32'(v)};
    endfunction

    function automatic logic [63:0] exp_cnt(input int n);
        if (!CNT_EN) return 64'd0;
        return (n > 1023) ? 64'd1023 : 64'(n);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [47:0] w);
        mem[c][wr_cnt[c]] = w;
        wr_cnt[c]++;
    endtask

    task automatic load(input int c, input int n, input int base);
        for (int k = 0; k < n; k++) push(c, wd(base + k));
        push(c, MARK);
    endtask

    task automatic do_reset();
        i_mv_ready = 1'b0;
        i_start    = 1'b0;
        i_col_done = 8'h00;
        reset      = 1'b1;
        fifo_clr   = 1'b1;
        for (int c = 0; c < 8; c++) wr_cnt[c] = 0;
        tick(2);
        reset    = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int t = 0;
        while (beats.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, 64'(beats.size()), 64'(n));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int t = 0;
        while (!o_all_done && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, 64'(o_all_done), 64'd1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int t = 0;
        while (!o_mv_valid && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, 64'(o_mv_valid), 64'd1);
    endtask

    initial begin
        int b0;
        int r0 [8];
        logic [47:0] held;
        int bad_hold;

        i_col_data = '0;
        for (int c = 0; c < 8; c++) rden_cnt[c] = 0;
        do_reset();
        check("rst_rden",  64'(o_col_rden), 64'd0);
        check("rst_valid", 64'(o_mv_valid), 64'd0);
        check("rst_data",  64'(o_mv_data),  64'd0);
        check("rst_busy",  64'(o_busy),     64'd0);
        check("rst_done",  64'(o_all_done), 64'd0);
        check("rst_count", 64'(o_mv_count), 64'd0);

        // Scenario 1: only column 3 has data; DONE waits on the other markers.
        b0 = beats.size();
        load(3, 3, 'h300);
        i_col_done = 8'h08;
        i_mv_ready = 1'b1;
        pulse_start();
        wait_beats(b0 + 3, 200, "s1_beats");
        tick(10);
        for (int k = 0; k < 3; k++) check($sformatf("s1_word%0d", k), 64'(beats[b0 + k]), 64'(wd('h300 + k)));
        check("s1_busy",     64'(o_busy),      64'd1);
        check("s1_not_done", 64'(o_all_done),  64'd0);
        check("s1_nbeats",   64'(beats.size()), 64'(b0 + 3));
        for (int c = 0; c < 8; c++) if (c != 3) push(c, MARK);
        i_col_done = 8'hFF;
        wait_done(200, "s1_done");
        check("s1_count", 64'(o_mv_count), exp_cnt(3));
        check("s1_idle_busy", 64'(o_busy), 64'd0);

        // Scenario 2: markers only, each column read exactly once.
        do_reset();
        b0 = beats.size();
        for (int c = 0; c < 8; c++) r0[c] = rden_cnt[c];
        for (int c = 0; c < 8; c++) push(c, MARK);
        i_col_done = 8'hFF;
        i_mv_ready = 1'b1;
        pulse_start();
        wait_done(200, "s2_done");
        check("s2_nbeats", 64'(beats.size()), 64'(b0));
        check("s2_count",  64'(o_mv_count),   64'd0);
        for (int c = 0; c < 8; c++) check($sformatf("s2_rden%0d", c), 64'(rden_cnt[c] - r0[c]), 64'd1);

        // Scenario 3: downstream stall holds the word and stops FIFO reads.
        do_reset();
        b0 = beats.size();
        load(0, 2, 'h30);
        i_col_done = 8'h01;
        pulse_start();
        wait_valid(100, "s3_valid");
        held = o_mv_data;
        check("s3_first", 64'(held), 64'(wd('h30)));
        bad_hold = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (!o_mv_valid || o_mv_data !== held || o_col_rden !== 8'd0) bad_hold++;
        end
        check("s3_stall_hold", 64'(bad_hold), 64'd0);
        i_mv_ready = 1'b1;
        wait_beats(b0 + 2, 100, "s3_beats");
        check("s3_beat0", 64'(beats[b0]),     64'(wd('h30)));
        check("s3_beat1", 64'(beats[b0 + 1]), 64'(wd('h31)));

        // Scenario 4: a marker on column 4 leaves rr_ptr at 5, so 6 beats 2.
        do_reset();
        b0 = beats.size();
        push(4, MARK);
        i_col_done = 8'h10;
        i_mv_ready = 1'b1;
        pulse_start();
        tick(12);
        load(2, 2, 'h20);
        load(6, 2, 'h60);
        i_col_done = 8'h54;
        wait_beats(b0 + 4, 200, "s4_beats");
        check("s4_w0", 64'(beats[b0]),     64'(wd('h60)));
        check("s4_w1", 64'(beats[b0 + 1]), 64'(wd('h61)));
        check("s4_w2", 64'(beats[b0 + 2]), 64'(wd('h20)));
        check("s4_w3", 64'(beats[b0 + 3]), 64'(wd('h21)));

        // Scenario 5: reset during OUT drops the word; restart begins at column 0.
        do_reset();
        b0 = beats.size();
        load(1, 3, 'h10);
        i_col_done = 8'h02;
        pulse_start();
        wait_valid(100, "s5_valid");
        reset = 1'b1;
        tick(1);
        check("s5_valid0", 64'(o_mv_valid), 64'd0);
        check("s5_busy0",  64'(o_busy),     64'd0);
        check("s5_count0", 64'(o_mv_count), 64'd0);
        reset = 1'b0;
        check("s5_nohs", 64'(beats.size()), 64'(b0));
        load(0, 1, 'h400);
        i_col_done = 8'h03;
        i_mv_ready = 1'b1;
        pulse_start();
        wait_beats(b0 + 3, 200, "s5_beats");
        check("s5_col0_first", 64'(beats[b0]),     64'(wd('h400)));
        check("s5_col1_next",  64'(beats[b0 + 1]), 64'(wd('h11)));
        check("s5_col1_last",  64'(beats[b0 + 2]), 64'(wd('h12)));

        // Scenario 6: 1030 words saturate the counter at 1023.
        do_reset();
        b0 = beats.size();
        load(7, 1030, 'h1000);
        i_col_done = 8'h80;
        i_mv_ready = 1'b1;
        pulse_start();
        wait_beats(b0 + 1030, 4000, "s6_beats");
        tick(4);
        check("s6_count", 64'(o_mv_count), exp_cnt(1030));
        check("s6_last",  64'(beats[b0 + 1029]), 64'(wd('h1000 + 1029)));

        check("rden_onehot", 64'(multi_hot), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 The block SHALL have a synchronous, active-high reset named reset and a clock named clk.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that begins a collection pass; ignored outside IDLE and DONE.
REQ-005 col_done  in  8  bit i high means column i's move list is complete and resident in its FIFO.
REQ-006 col_empty  in  8  bit i high means column i's FIFO holds no word.
REQ-007 col_rden  out  8  one-hot read enable to the column FIFOs; at most one bit high per cycle.
REQ-008 col_data  in  384  column i's word on bits [48*i+47:48*i]; valid the cycle after col_rden[i].
REQ-009 mv_data  out  48  current merged move word.
REQ-010 mv_valid  out  1  mv_data is valid; held until accepted.
REQ-011 mv_ready  in  1  downstream accepts the word when mv_valid and mv_ready are both high.
REQ-012 busy  out  1  high in every state except IDLE and DONE.
REQ-013 all_done  out  1  high while in DONE.
REQ-014 mv_count  out  10  number of non-marker words accepted downstream in the current pass.

Function
REQ-015 States SHALL be IDLE, SCAN, READ, CAPT, OUT and DONE.
REQ-016 IDLE/DONE + start -> SCAN; finished[7:0] cleared, rr_ptr set to 0, mv_count cleared.
REQ-017 A column is eligible when col_done[i], ~finished[i] and ~col_empty[i] are all high.
REQ-018 SCAN: select the first eligible column at or above rr_ptr (wrapping 7 -> 0), then go to READ; stay in SCAN if none is eligible.
REQ-019 SCAN: if finished == 8'hFF, go to DONE instead; this check takes priority over selection.
REQ-020 READ: assert col_rden for the selected column for exactly one cycle, then go to CAPT.
REQ-021 CAPT: register col_data of the selected column.
REQ-022 CAPT end-of-list test: a word is an end marker when all eight 6-bit fields are equal.
REQ-023 CAPT, end marker: set finished[sel], advance rr_ptr to sel+1 mod 8, return to SCAN; the marker is not forwarded.
REQ-024 CAPT, non-marker: go to OUT with mv_valid high.
REQ-025 OUT: hold mv_data and mv_valid stable until mv_ready; on acceptance go to READ for the same column if it is still non-empty, else to SCAN.
REQ-026 The same column SHALL be drained until its marker; round-robin advances only on a marker.
REQ-027 mv_count SHALL increment on each accepted word and saturate at 1023.
REQ-028 col_rden SHALL be zero in all states except READ.
REQ-029 mv_ready with mv_valid low SHALL have no effect.
REQ-030 start while busy SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE; clear col_rden, mv_valid, mv_data, finished, rr_ptr and mv_count to 0; and drive busy and all_done low.
REQ-032 reset asserted mid-pass, including during OUT, SHALL abandon the pending word with no downstream handshake.
REQ-033 reset SHALL take priority over start on the same edge.

Configuration
REQ-034 Macro MOVE_COUNT_EN defined: mv_count behaves per REQ-027.
REQ-035 MOVE_COUNT_EN undefined: the counter is not built, mv_count is tied to 0, and all other behaviour is identical.

Verification
REQ-036 Scenario 1: column 3 only, three words then a marker, mv_ready=1 -> three mv_valid beats in order; DONE is not reached until the other seven columns deliver their markers; mv_count=3.
REQ-037 Scenario 2: all eight columns hold only a marker -> no mv_valid; all_done=1; mv_count=0; each col_rden bit pulses exactly once.
REQ-038 Scenario 3: column 0 holds two words plus a marker, mv_ready low for 5 cycles -> mv_data stable and mv_valid high throughout; no col_rden during the stall.
REQ-039 Scenario 4: columns 2 and 6 both eligible with rr_ptr=5 -> column 6 is served first and drained, then column 2.
REQ-040 Scenario 5: reset asserted in OUT -> next cycle mv_valid=0, busy=0, mv_count=0; a following start restarts from column 0.
REQ-041 Scenario 6: 1030 words with MOVE_COUNT_EN defined -> mv_count=1023; with the macro undefined -> mv_count=0.
